// File: rtl/rotate_iter.sv
// rotate_iter: multi-cycle rotate unit (ror/rol/rcr/rcl) on a WIDTH-bit operand
// or on its low half. Each RUN clock performs up to STEP single-bit steps.
// Optional macro ROTATE_ITER_SHIFT_EN: func[2]=1 selects shl/shr/sar.
module rotate_iter #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             ready,
  output logic             busy,
  output logic             done,
  input  logic [WIDTH-1:0] x,
  input  logic [CNT_W-1:0] y,
  input  logic [2:0]       func,
  input  logic             cfi,
  input  logic             ofi,
  input  logic             word_op,
  output logic [WIDTH-1:0] out,
  output logic             cfo,
  output logic             ofo
);

  localparam int H = WIDTH / 2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_rem;
  logic [WIDTH-1:0] r_d;
  logic             r_c;
  logic [2:0]       r_func;
  logic             r_word;
  logic             r_xmsb;   // operand msb of the field, needed for the shr flag
  logic             r_ready, r_busy, r_done;
  logic [WIDTH-1:0] r_out;
  logic             r_cfo, r_ofo;

  logic [2:0]       w_fn_in;
  logic [WIDTH-1:0] w_d;
  logic             w_c;
  logic [WIDTH:0]   w_t;
  logic             w_last;
  logic [CNT_W-1:0] w_rem_nxt;
  logic             w_ofo;

`ifdef ROTATE_ITER_SHIFT_EN
  assign w_fn_in = func;
`else
  // Rotate-only build: the shift select bit is dropped at load time
  logic w_unused;
  assign w_unused = func[2];
  assign w_fn_in  = {1'b0, func[1:0]};
`endif

  // One single-bit step on the effective field; returns {carry, data}.
  // Left ops feed a bit into the lsb and carry out the old msb, right ops
  // feed the msb of the field and carry out the old lsb.
  function automatic logic [WIDTH:0] f_step(input logic [WIDTH-1:0] d, input logic c,
                                            input logic [2:0] fn, input logic wd);
    logic             msb, left, in_b, c_n;
    logic [WIDTH-1:0] d_n;
    msb  = wd ? d[WIDTH-1] : d[H-1];
    left = fn[2] ? ~fn[0] : fn[0];
    if (left) begin
      in_b = fn[2] ? 1'b0 : (fn[1] ? c : msb);
      c_n  = msb;
      d_n  = wd ? {d[WIDTH-2:0], in_b} : {d[WIDTH-1:H], d[H-2:0], in_b};
    end else begin
      if (fn[2]) in_b = fn[1] ? msb : 1'b0;
      else       in_b = fn[1] ? c : d[0];
      c_n  = d[0];
      d_n  = wd ? {in_b, d[WIDTH-1:1]} : {d[WIDTH-1:H], in_b, d[H-1:1]};
    end
    return {c_n, d_n};
  endfunction

  // Overflow flag of a finished operation (count known to be non-zero)
  function automatic logic f_ofo(input logic [WIDTH-1:0] d, input logic c,
                                 input logic [2:0] fn, input logic wd, input logic xmsb);
    logic msb, msb2;
    msb  = wd ? d[WIDTH-1] : d[H-1];
    msb2 = wd ? d[WIDTH-2] : d[H-2];
    if (fn[2]) return (~fn[0]) ? (c ^ msb) : (fn[1] ? 1'b0 : xmsb);
    else       return fn[0] ? (c ^ msb) : (msb ^ msb2);
  endfunction

  // Apply min(rem, STEP) single-bit steps to the working data and carry
  always_comb begin
    w_t = {r_c, r_d};
    for (int i = 0; i < STEP; i++) begin
      if (i < int'(r_rem)) w_t = f_step(w_t[WIDTH-1:0], w_t[WIDTH], r_func, r_word);
    end
    w_c = w_t[WIDTH];
    w_d = w_t[WIDTH-1:0];
  end

  assign w_last    = (int'(r_rem) <= STEP);
  assign w_rem_nxt = w_last ? '0 : (r_rem - CNT_W'(STEP));
  assign w_ofo     = f_ofo(w_d, w_c, r_func, r_word, r_xmsb);

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
      r_d     <= '0;
      r_c     <= 1'b0;
      r_func  <= '0;
      r_word  <= 1'b0;
      r_xmsb  <= 1'b0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_out   <= '0;
      r_cfo   <= 1'b0;
      r_ofo   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_d     <= x;
            r_c     <= cfi;
            r_func  <= w_fn_in;
            r_word  <= word_op;
            r_xmsb  <= word_op ? x[WIDTH-1] : x[H-1];
            r_rem   <= y;
            r_ready <= 1'b0;
            if (y == '0) begin
              // Zero count: pass operand and flags straight through
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_out   <= x;
              r_cfo   <= cfi;
              r_ofo   <= ofi;
            end else begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          r_d   <= w_d;
          r_c   <= w_c;
          r_rem <= w_rem_nxt;
          if (w_last) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_out   <= w_d;
            r_cfo   <= w_c;
            r_ofo   <= w_ofo;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_ready <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ready = r_ready;
  assign busy  = r_busy;
  assign done  = r_done;
  assign out   = r_out;
  assign cfo   = r_cfo;
  assign ofo   = r_ofo;

endmodule

// File: tb/tb_rotate_iter.sv
// Bench for rotate_iter: two instances (STEP=1 and STEP=4) sharing inputs,
// a ring-arithmetic reference model and a per-cycle compare process.
module tb_rotate_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sel = 1'b0;      // 0: STEP=1 instance, 1: STEP=4 instance
  logic [15:0] x = '0;
  logic [4:0]  y = '0;
  logic [2:0]  func = '0;
  logic        cfi = 1'b0, ofi = 1'b0, word_op = 1'b0;

  logic        rdy1, bsy1, dn1, cf1, of1;
  logic [15:0] out1;
  logic        rdy4, bsy4, dn4, cf4, of4;
  logic [15:0] out4;
  logic        st1, st4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign st1 = start & ~sel;
  assign st4 = start & sel;

  rotate_iter #(.WIDTH(16), .CNT_W(5), .STEP(1)) u_s1 (
    .clk(clk), .rst(rst), .start(st1), .ready(rdy1), .busy(bsy1), .done(dn1),
    .x(x), .y(y), .func(func), .cfi(cfi), .ofi(ofi), .word_op(word_op),
    .out(out1), .cfo(cf1), .ofo(of1));

  rotate_iter #(.WIDTH(16), .CNT_W(5), .STEP(4)) u_s4 (
    .clk(clk), .rst(rst), .start(st4), .ready(rdy4), .busy(bsy4), .done(dn4),
    .x(x), .y(y), .func(func), .cfi(cfi), .ofi(ofi), .word_op(word_op),
    .out(out4), .cfo(cf4), .ofo(of4));

  logic        d_ready, d_busy, d_done, d_cfo, d_ofo;
  logic [15:0] d_out;
  assign d_ready = sel ? rdy4 : rdy1;
  assign d_busy  = sel ? bsy4 : bsy1;
  assign d_done  = sel ? dn4  : dn1;
  assign d_out   = sel ? out4 : out1;
  assign d_cfo   = sel ? cf4  : cf1;
  assign d_ofo   = sel ? of4  : of1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: whole-count result from ring rotation / plain shifts
  function automatic void m_calc(input logic [15:0] xx, input logic [4:0] yy, input logic [2:0] fn,
                                 input logic ci, input logic oi, input logic wd,
                                 output logic [15:0] o, output logic co, output logic oo);
    int          e, n, r;
    logic [63:0] mask, m2, f, v, res, sx, t;
    bit          shift, left;
    e    = wd ? 16 : 8;
    n    = int'(yy);
    mask = (64'd1 << e) - 64'd1;
    f    = 64'(xx) & mask;
`ifdef ROTATE_ITER_SHIFT_EN
    shift = fn[2];
`else
    shift = 1'b0;
`endif
    if (n == 0) begin
      o = xx; co = ci; oo = oi;
      return;
    end
    res = '0; co = 1'b0;
    if (!shift) begin
      left = fn[0];
      if (!fn[1]) begin
        r = n % e;
        if (left) res = ((f << r) | (f >> (e - r))) & mask;
        else      res = ((f >> r) | (f << (e - r))) & mask;
        co = left ? res[0] : res[e-1];
      end else begin
        // carry is bit E of an (E+1)-bit ring
        m2 = (64'd1 << (e + 1)) - 64'd1;
        v  = f | (64'(ci) << e);
        r  = n % (e + 1);
        if (left) v = ((v << r) | (v >> (e + 1 - r))) & m2;
        else      v = ((v >> r) | (v << (e + 1 - r))) & m2;
        res = v & mask;
        co  = v[e];
      end
      oo = left ? (co ^ res[e-1]) : (res[e-1] ^ res[e-2]);
    end else begin
      left = ~fn[0];
      if (left) begin
        res = (f << n) & mask;
        t   = f << (n - 1);
        co  = t[e-1];
        oo  = co ^ res[e-1];
      end else begin
        sx  = (fn[1] && f[e-1]) ? (f | ~mask) : f;
        res = (sx >> n) & mask;
        t   = sx >> (n - 1);
        co  = t[0];
        oo  = fn[1] ? 1'b0 : f[e-1];
      end
    end
    o = (xx & ~mask[15:0]) | res[15:0];
  endfunction

  // Model: result of the current inputs and its latency on the selected instance
  logic [15:0] c_out;
  logic        c_cfo, c_ofo;
  int          c_lat;
  always @* begin
    m_calc(x, y, func, cfi, ofi, word_op, c_out, c_cfo, c_ofo);
    c_lat = (int'(y) + (sel ? 4 : 1) - 1) / (sel ? 4 : 1);
  end

  // Model phase: 0 idle, 1 running, 2 done
  int          m_ph, m_left;
  logic [15:0] m_out, p_out;
  logic        m_cfo, m_ofo, p_cfo, p_ofo;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph <= 0; m_left <= 0;
      m_out <= '0; m_cfo <= 1'b0; m_ofo <= 1'b0;
      p_out <= '0; p_cfo <= 1'b0; p_ofo <= 1'b0;
    end else begin
      case (m_ph)
        0: if (start) begin
          if (c_lat == 0) begin
            m_ph <= 2; m_out <= c_out; m_cfo <= c_cfo; m_ofo <= c_ofo;
          end else begin
            m_ph <= 1; m_left <= c_lat;
            p_out <= c_out; p_cfo <= c_cfo; p_ofo <= c_ofo;
          end
        end
        1: begin
          m_left <= m_left - 1;
          if (m_left == 1) begin
            m_ph <= 2; m_out <= p_out; m_cfo <= p_cfo; m_ofo <= p_ofo;
          end
        end
        default: m_ph <= 0;
      endcase
    end
  end

  // Per-cycle compare of the selected instance against the model
  always @(negedge clk) begin
    if (!rst) begin
      chk("cyc ready", 32'(d_ready), 32'(m_ph == 0));
      chk("cyc busy",  32'(d_busy),  32'(m_ph == 1));
      chk("cyc done",  32'(d_done),  32'(m_ph == 2));
      chk("cyc out",   32'(d_out),   32'(m_out));
      chk("cyc cfo",   32'(d_cfo),   32'(m_cfo));
      chk("cyc ofo",   32'(d_ofo),   32'(m_ofo));
    end
  end

  task automatic do_reset(input logic new_sel);
    @(negedge clk); #2 rst = 1'b1; sel = new_sel;
    @(negedge clk); #1;
    chk("rst ready", 32'(d_ready), 32'd1);
    chk("rst busy",  32'(d_busy),  32'd0);
    chk("rst done",  32'(d_done),  32'd0);
    chk("rst out",   32'(d_out),   32'd0);
    #1 rst = 1'b0;
  endtask

  task automatic run_op(input string nm, input logic [15:0] xx, input logic [4:0] yy,
                        input logic [2:0] fn, input logic ci, input logic oi, input logic wd,
                        input logic [15:0] eo, input logic ec, input logic eof,
                        input int elat, input bit extra);
    int edges;
    bit got;
    @(negedge clk);
    x = xx; y = yy; func = fn; cfi = ci; ofi = oi; word_op = wd; start = 1'b1;
    @(posedge clk); edges = 0;
    @(negedge clk); start = 1'b0;
    got = 1'b0;
    while (!got && edges < 200) begin
      if (d_done) got = 1'b1;
      else begin
        if (extra && edges == 2) begin
          start = 1'b1; x = ~xx; y = 5'd1;
        end
        @(posedge clk); edges++;
        @(negedge clk); start = 1'b0;
      end
    end
    chk({nm, " done seen"}, 32'(got), 32'd1);
    chk({nm, " latency"}, 32'(edges), 32'(elat));
    chk({nm, " out"}, 32'(d_out), 32'(eo));
    chk({nm, " cfo"}, 32'(d_cfo), 32'(ec));
    chk({nm, " ofo"}, 32'(d_ofo), 32'(eof));
  endtask

  task automatic quiet(input string nm, input int cycles);
    int dn;
    dn = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (d_done) dn++;
    end
    chk({nm, " no done"}, 32'(dn), 32'd0);
  endtask

  initial begin
    logic [15:0] eo;
    logic        ec, eof;

    do_reset(1'b0);

    // Hand-computed vectors
    run_op("t1 ror",   16'h8001, 5'd1,  3'b000, 1'b0, 1'b0, 1'b1, 16'hC000, 1'b1, 1'b0, 1,  1'b0);
    run_op("t2 rcl8",  16'hAB80, 5'd9,  3'b011, 1'b0, 1'b0, 1'b0, 16'hAB80, 1'b0, 1'b1, 9,  1'b0);
    run_op("t2 rcr17", 16'h0001, 5'd17, 3'b010, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0, 17, 1'b0);
    run_op("t3 rol",   16'h8000, 5'd1,  3'b001, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b1, 1,  1'b0);
    run_op("t3 n0",    16'h8000, 5'd0,  3'b001, 1'b1, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b0, 0,  1'b0);
`ifdef ROTATE_ITER_SHIFT_EN
    run_op("t6 sar",   16'h8000, 5'd3,  3'b111, 1'b0, 1'b0, 1'b1, 16'hF000, 1'b0, 1'b0, 3,  1'b0);
    run_op("shl8",     16'h12C5, 5'd2,  3'b100, 1'b0, 1'b1, 1'b0, 16'h1214, 1'b1, 1'b1, 2,  1'b0);
    run_op("shr",      16'h8003, 5'd2,  3'b101, 1'b0, 1'b0, 1'b1, 16'h2000, 1'b1, 1'b1, 2,  1'b0);
`else
    run_op("t6 rcl",   16'h8000, 5'd3,  3'b111, 1'b0, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b0, 3,  1'b0);
`endif
    // Identity at n = E for a plain rotate on the half field
    run_op("rol8 id",  16'h5AC3, 5'd8,  3'b001, 1'b0, 1'b0, 1'b0, 16'h5AC3, 1'b1, 1'b0, 8,  1'b0);

    // Model-derived vectors
    m_calc(16'h12C5, 5'd3, 3'b000, 1'b0, 1'b0, 1'b0, eo, ec, eof);
    run_op("ror8",  16'h12C5, 5'd3,  3'b000, 1'b0, 1'b0, 1'b0, eo, ec, eof, 3, 1'b0);
    m_calc(16'h5A3C, 5'd5, 3'b010, 1'b1, 1'b0, 1'b0, eo, ec, eof);
    run_op("rcr8",  16'h5A3C, 5'd5,  3'b010, 1'b1, 1'b0, 1'b0, eo, ec, eof, 5, 1'b0);
    m_calc(16'h4321, 5'd20, 3'b001, 1'b0, 1'b1, 1'b1, eo, ec, eof);
    run_op("rol20", 16'h4321, 5'd20, 3'b001, 1'b0, 1'b1, 1'b1, eo, ec, eof, 20, 1'b0);
    m_calc(16'hF00F, 5'd16, 3'b011, 1'b1, 1'b0, 1'b1, eo, ec, eof);
    run_op("rcl16", 16'hF00F, 5'd16, 3'b011, 1'b1, 1'b0, 1'b1, eo, ec, eof, 16, 1'b0);

    // Reset in the middle of a long operation
    @(negedge clk);
    x = 16'h1234; y = 5'd31; func = 3'b000; word_op = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); #2 rst = 1'b1;
    #1;
    chk("t5 ready", 32'(d_ready), 32'd1);
    chk("t5 busy",  32'(d_busy),  32'd0);
    chk("t5 done",  32'(d_done),  32'd0);
    chk("t5 out",   32'(d_out),   32'd0);
    #1 rst = 1'b0;
    quiet("t5", 40);

    // STEP=4 instance: 31 rors in 8 edges, second start during RUN ignored
    do_reset(1'b1);
    run_op("t4 step4", 16'h1234, 5'd31, 3'b000, 1'b0, 1'b0, 1'b1, 16'h2468, 1'b0, 1'b0, 8, 1'b1);
    quiet("t4", 12);
    run_op("step4 rcr", 16'h0001, 5'd17, 3'b010, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0, 5, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
